// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: opcodes, operand addresses and FSM states for the command sequencer
package sys_ctrl_pkg;
    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
    localparam int OP_A_ADDR = 0;
    localparam int OP_B_ADDR = 1;
    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
        ALU_FUN_S, ALU_WAIT, TX_LO, TX_HI, TX_RD
    } state_t;
endpackage

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: decodes UART command frames into register/ALU operations and pushes responses to the TX FIFO
module sys_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    REF_CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
    input  logic                    RX_D_VALID,
    input  logic [DATA_WIDTH-1:0]   RdData,
    input  logic                    RdData_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic                    FIFO_FULL,
    output logic                    WrEn,
    output logic                    RdEn,
    output logic [ADDR_WIDTH-1:0]   Address,
    output logic [DATA_WIDTH-1:0]   WrData,
    output logic                    ALU_EN,
    output logic [FUN_WIDTH-1:0]    ALU_FUN,
    output logic                    CLK_EN,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VALID
);
    state_t state, state_d;
    logic started, started_d;
    logic [DATA_WIDTH-1:0] hi_byte, hi_d;
    logic wr_d, rd_d, aen_d, cen_d, txv_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d, txd_d;
    logic [FUN_WIDTH-1:0] fun_d;
    always_ff @(posedge REF_CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            started    <= 1'b0;
            hi_byte    <= '0;
            WrEn       <= 1'b0;
            RdEn       <= 1'b0;
            Address    <= '0;
            WrData     <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            CLK_EN     <= 1'b0;
            TX_P_DATA  <= '0;
            TX_D_VALID <= 1'b0;
        end else begin
            state      <= state_d;
            started    <= started_d;
            hi_byte    <= hi_d;
            WrEn       <= wr_d;
            RdEn       <= rd_d;
            Address    <= addr_d;
            WrData     <= wdata_d;
            ALU_EN     <= aen_d;
            ALU_FUN    <= fun_d;
            CLK_EN     <= cen_d;
            TX_P_DATA  <= txd_d;
            TX_D_VALID <= txv_d;
        end
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:      state_d = !RX_D_VALID ? IDLE :
                                 RX_P_DATA == CMD_WR      ? WR_ADDR :
                                 RX_P_DATA == CMD_RD      ? RD_ADDR :
                                 RX_P_DATA == CMD_ALU_OP  ? OP_A :
                                 RX_P_DATA == CMD_ALU_NOP ? ALU_FUN_S : IDLE;
            WR_ADDR:   state_d = RX_D_VALID ? WR_DATA : WR_ADDR;
            WR_DATA:   state_d = RX_D_VALID ? IDLE : WR_DATA;
            RD_ADDR:   state_d = RX_D_VALID ? RD_WAIT : RD_ADDR;
            RD_WAIT:   state_d = RdData_Valid ? TX_RD : RD_WAIT;
            OP_A:      state_d = RX_D_VALID ? OP_B : OP_A;
            OP_B:      state_d = RX_D_VALID ? ALU_FUN_S : OP_B;
            ALU_FUN_S: state_d = RX_D_VALID ? ALU_WAIT : ALU_FUN_S;
            ALU_WAIT:  state_d = (started && OUT_Valid) ? TX_LO : ALU_WAIT;
            TX_LO:     state_d = TX_D_VALID ? TX_HI : TX_LO;
            TX_HI:     state_d = TX_D_VALID ? IDLE : TX_HI;
            TX_RD:     state_d = TX_D_VALID ? IDLE : TX_RD;
            default:   state_d = IDLE;
        endcase
    end
    always_comb begin
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        aen_d     = 1'b0;
        txv_d     = 1'b0;
        addr_d    = Address;
        wdata_d   = WrData;
        fun_d     = ALU_FUN;
        cen_d     = CLK_EN;
        txd_d     = TX_P_DATA;
        hi_d      = hi_byte;
        started_d = started;
        case (state)
            WR_ADDR: addr_d = RX_D_VALID ? RX_P_DATA[ADDR_WIDTH-1:0] : Address;
            WR_DATA: begin
                wr_d    = RX_D_VALID;
                wdata_d = RX_D_VALID ? RX_P_DATA : WrData;
            end
            RD_ADDR: begin
                rd_d   = RX_D_VALID;
                addr_d = RX_D_VALID ? RX_P_DATA[ADDR_WIDTH-1:0] : Address;
            end
            RD_WAIT: begin
                txd_d = RdData_Valid ? RdData : TX_P_DATA;
                txv_d = RdData_Valid && !FIFO_FULL;
            end
            OP_A, OP_B: begin
                wr_d    = RX_D_VALID;
                addr_d  = !RX_D_VALID ? Address :
                          state == OP_A ? ADDR_WIDTH'(OP_A_ADDR) : ADDR_WIDTH'(OP_B_ADDR);
                wdata_d = RX_D_VALID ? RX_P_DATA : WrData;
            end
            ALU_FUN_S: begin
                fun_d = RX_D_VALID ? RX_P_DATA[FUN_WIDTH-1:0] : ALU_FUN;
                cen_d = CLK_EN || RX_D_VALID;
            end
            ALU_WAIT: begin
                aen_d     = !started;
                started_d = !(started && OUT_Valid);
                txd_d     = (started && OUT_Valid) ? ALU_OUT[DATA_WIDTH-1:0] : TX_P_DATA;
                hi_d      = (started && OUT_Valid) ? ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH] : hi_byte;
                txv_d     = started && OUT_Valid && !FIFO_FULL;
                cen_d     = !(started && OUT_Valid);
            end
            TX_LO: begin
                txd_d = TX_D_VALID ? hi_byte : TX_P_DATA;
                txv_d = !FIFO_FULL;
            end
            TX_HI, TX_RD: txv_d = !TX_D_VALID && !FIFO_FULL;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb_sys_cmd_ctrl: table-driven cycle vectors plus directed back-pressure and reset sequences
module tb_sys_cmd_ctrl;
    logic REF_CLK, RST;
    logic [7:0] RX_P_DATA, RdData, WrData, TX_P_DATA;
    logic RX_D_VALID, RdData_Valid, OUT_Valid, FIFO_FULL;
    logic [15:0] ALU_OUT;
    logic WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VALID;
    logic [3:0] Address, ALU_FUN;
    int total = 0;
    int bad = 0;
    typedef struct packed {
        logic [35:0] stim;
        logic [28:0] exp;
    } vec_t;
    vec_t tbl [20];
    logic [7:0] pushed [$];
    sys_cmd_ctrl dut (
        .REF_CLK(REF_CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VALID(RX_D_VALID),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
        .FIFO_FULL(FIFO_FULL), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA),
        .TX_D_VALID(TX_D_VALID)
    );
    initial REF_CLK = 1'b0;
    always #5 REF_CLK = ~REF_CLK;
    function automatic logic [35:0] st(int rxv, int rxd, int rdv, int rdd, int ov, int alu, int full);
        return {1'(rxv), 8'(rxd), 1'(rdv), 8'(rdd), 1'(ov), 16'(alu), 1'(full)};
    endfunction
    function automatic logic [28:0] ex(int wr, int rd, int addr, int wd, int aen, int fun, int cen, int txv, int txd);
        return {1'(wr), 1'(rd), 4'(addr), 8'(wd), 1'(aen), 4'(fun), 1'(cen), 1'(txv), 8'(txd)};
    endfunction
    function automatic logic [28:0] outs();
        return {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_EN, TX_D_VALID, TX_P_DATA};
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        @(negedge REF_CLK);
        RX_D_VALID = 1'b1;
        RX_P_DATA  = b;
        @(posedge REF_CLK);
        #1;
        RX_D_VALID = 1'b0;
    endtask
    initial begin
        tbl[0]  = '{st(1,'hAA,0,0,0,0,0),      ex(0,0,5'h0,'h00,0,0,0,0,'h00)};
        tbl[1]  = '{st(1,'h05,0,0,0,0,0),      ex(0,0,5,'h00,0,0,0,0,'h00)};
        tbl[2]  = '{st(1,'h3C,0,0,0,0,0),      ex(1,0,5,'h3C,0,0,0,0,'h00)};
        tbl[3]  = '{st(0,0,0,0,0,0,0),         ex(0,0,5,'h3C,0,0,0,0,'h00)};
        tbl[4]  = '{st(1,'hBB,0,0,0,0,0),      ex(0,0,5,'h3C,0,0,0,0,'h00)};
        tbl[5]  = '{st(1,'h05,0,0,0,0,0),      ex(0,1,5,'h3C,0,0,0,0,'h00)};
        tbl[6]  = '{st(0,0,0,0,0,0,0),         ex(0,0,5,'h3C,0,0,0,0,'h00)};
        tbl[7]  = '{st(0,0,1,'h3C,0,0,0),      ex(0,0,5,'h3C,0,0,0,1,'h3C)};
        tbl[8]  = '{st(0,0,0,0,0,0,0),         ex(0,0,5,'h3C,0,0,0,0,'h3C)};
        tbl[9]  = '{st(1,'hCC,0,0,0,0,0),      ex(0,0,5,'h3C,0,0,0,0,'h3C)};
        tbl[10] = '{st(1,'h0A,0,0,0,0,0),      ex(1,0,0,'h0A,0,0,0,0,'h3C)};
        tbl[11] = '{st(1,'h03,0,0,0,0,0),      ex(1,0,1,'h03,0,0,0,0,'h3C)};
        tbl[12] = '{st(1,'h00,0,0,0,0,0),      ex(0,0,1,'h03,0,0,1,0,'h3C)};
        tbl[13] = '{st(0,0,0,0,0,0,0),         ex(0,0,1,'h03,1,0,1,0,'h3C)};
        tbl[14] = '{st(0,0,0,0,1,'h000D,0),    ex(0,0,1,'h03,0,0,0,1,'h0D)};
        tbl[15] = '{st(0,0,0,0,0,0,0),         ex(0,0,1,'h03,0,0,0,1,'h00)};
        tbl[16] = '{st(0,0,0,0,0,0,0),         ex(0,0,1,'h03,0,0,0,0,'h00)};
        tbl[17] = '{st(1,'h55,0,0,0,0,0),      ex(0,0,1,'h03,0,0,0,0,'h00)};
        tbl[18] = '{st(0,0,1,'h77,1,'hABCD,0), ex(0,0,1,'h03,0,0,0,0,'h00)};
        tbl[19] = '{st(1,'h05,0,0,0,0,0),      ex(0,0,1,'h03,0,0,0,0,'h00)};
        RST = 1'b0;
        {RX_D_VALID, RX_P_DATA, RdData_Valid, RdData, OUT_Valid, ALU_OUT, FIFO_FULL} = '0;
        repeat (3) @(posedge REF_CLK);
        #1;
        chk("reset", 32'(outs()), 32'h0);
        @(negedge REF_CLK);
        RST = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge REF_CLK);
            {RX_D_VALID, RX_P_DATA, RdData_Valid, RdData, OUT_Valid, ALU_OUT, FIFO_FULL} = tbl[i].stim;
            @(posedge REF_CLK);
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end
        @(negedge REF_CLK);
        {RX_D_VALID, RX_P_DATA, RdData_Valid, RdData, OUT_Valid, ALU_OUT, FIFO_FULL} = '0;
        send(8'hDD);
        send(8'h02);
        chk("nop_clk_en", {30'b0, CLK_EN, ALU_EN}, 32'h2);
        @(posedge REF_CLK);
        #1;
        chk("nop_alu_en", {27'b0, ALU_EN, ALU_FUN}, 32'h12);
        @(negedge REF_CLK);
        OUT_Valid = 1'b1;
        ALU_OUT   = 16'h1234;
        FIFO_FULL = 1'b1;
        @(posedge REF_CLK);
        #1;
        OUT_Valid = 1'b0;
        chk("bp_latch", {22'b0, CLK_EN, TX_D_VALID, TX_P_DATA}, 32'h34);
        for (int i = 0; i < 5; i++) begin
            @(posedge REF_CLK);
            #1;
            chk($sformatf("bp_hold%0d", i), {23'b0, TX_D_VALID, TX_P_DATA}, 32'h34);
        end
        @(negedge REF_CLK);
        FIFO_FULL = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge REF_CLK);
            #1;
            if (TX_D_VALID) pushed.push_back(TX_P_DATA);
        end
        chk("bp_count", 32'(pushed.size()), 32'd2);
        if (pushed.size() == 2) chk("bp_bytes", {16'b0, pushed[0], pushed[1]}, 32'h3412);
        send(8'hAA);
        send(8'h05);
        chk("abort_addr", 32'(Address), 32'h5);
        #2 RST = 1'b0;
        #1 chk("abort_async", 32'(outs()), 32'h0);
        @(negedge REF_CLK);
        RST = 1'b1;
        send(8'h3C);
        chk("abort_no_wr", {31'b0, WrEn}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge REF_CLK);
            #1;
            chk($sformatf("abort_idle%0d", i), 32'(outs()), 32'h0);
        end
        send(8'hAA);
        send(8'h01);
        send(8'hFF);
        chk("fresh_wr", {19'b0, WrEn, Address, WrData}, {19'b0, 1'b1, 4'h1, 8'hFF});
        @(posedge REF_CLK);
        #1;
        chk("fresh_wr_end", {31'b0, WrEn}, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sys_cmd_ctrl.md
# sys_cmd_ctrl

Command sequencer between the UART byte stream and the system core, running in the REF_CLK domain. It decodes frames of received bytes into register-file writes and reads and ALU operations. Response bytes are pushed into the TX FIFO that feeds the UART transmitter. It also gates the ALU clock so the ALU only toggles while an operation is in flight.

## Interface
- DATA_WIDTH, 8, byte width of UART payload and register-file data
- ADDR_WIDTH, 4, register-file address width
- FUN_WIDTH, 4, ALU function-code width

- REF_CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte, already synchronized to REF_CLK
- RX_D_VALID  in  1  single-cycle pulse qualifying RX_P_DATA
- RdData  in  DATA_WIDTH  register-file read data
- RdData_Valid  in  1  pulse qualifying RdData
- ALU_OUT  in  2*DATA_WIDTH  ALU result
- OUT_Valid  in  1  pulse qualifying ALU_OUT
- FIFO_FULL  in  1  TX FIFO full
- WrEn  out  1  register-file write strobe
- RdEn  out  1  register-file read strobe
- Address  out  ADDR_WIDTH  register-file address
- WrData  out  DATA_WIDTH  register-file write data
- ALU_EN  out  1  ALU start strobe
- ALU_FUN  out  FUN_WIDTH  ALU function select
- CLK_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
- TX_D_VALID  out  1  TX FIFO write strobe

## Operation
- Command bytes:
  - 0xAA: register write. Frame is addr, data.
  - 0xBB: register read. Frame is addr. The controller returns 1 byte.
  - 0xCC: ALU with operands. Frame is A, B, fun. A is written to address 0 and B to address 1. The controller returns 2 bytes.
  - 0xDD: ALU without operands. Frame is fun. The controller returns 2 bytes.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN_S, ALU_WAIT, TX_LO, TX_HI, TX_RD.
- IDLE:
  - On RX_D_VALID, the byte selects the next state: WR_ADDR, RD_ADDR, OP_A or ALU_FUN_S.
  - Any other byte is dropped and the state stays IDLE.
- Each frame byte is consumed only on RX_D_VALID. In any state that is not waiting for a byte, RX_D_VALID is ignored and the byte is lost.
- Address bytes are truncated to their low ADDR_WIDTH bits. Function bytes are truncated to their low FUN_WIDTH bits.
- RD_WAIT: latch RdData on RdData_Valid, then go to TX_RD.
- ALU_WAIT: latch ALU_OUT on OUT_Valid, then go to TX_LO, then TX_HI.
- Each TX state:
  - Holds TX_P_DATA while FIFO_FULL=1.
  - Pulses TX_D_VALID for 1 cycle in the first cycle with FIFO_FULL=0.
  - Then advances: TX_LO goes to TX_HI; TX_HI and TX_RD go to IDLE.
- Byte order of the ALU result: ALU_OUT[7:0] first, then ALU_OUT[15:8].

## Timing
- All outputs are registered.
- Reset values: every strobe is 0, Address/WrData/ALU_FUN/TX_P_DATA are 0, CLK_EN is 0, state is IDLE.
- Asserting RST mid-frame aborts the frame. Outputs return to reset values asynchronously and no partial transaction completes.
- Write: WrEn, Address and WrData are valid in the cycle after the data byte's RX_D_VALID, for exactly 1 cycle.
- Read:
  - RdEn and Address are valid in the cycle after the address byte, for exactly 1 cycle.
  - RD_WAIT has no timeout.
- 0xCC operand writes:
  - A produces WrEn with Address=0 one cycle after A's RX_D_VALID.
  - B produces WrEn with Address=1 one cycle after B's RX_D_VALID.
- ALU:
  - CLK_EN rises 1 cycle after the fun byte.
  - ALU_EN (1-cycle pulse, with ALU_FUN valid) follows 1 cycle after CLK_EN rises.
  - CLK_EN stays high until the cycle after OUT_Valid.
  - OUT_Valid arriving in the same cycle as ALU_EN is accepted.
- TX: if FIFO_FULL=0 on entry, TX_D_VALID is asserted in the first cycle of the TX state. Minimum 1 cycle per byte, no back-to-back gap required.
- RdData_Valid or OUT_Valid seen outside the matching wait state is ignored.

## Structure
- Package sys_ctrl_pkg holds:
  - the command opcodes CMD_WR=8'hAA, CMD_RD=8'hBB, CMD_ALU_OP=8'hCC, CMD_ALU_NOP=8'hDD
  - the state enum
  - the operand addresses OP_A_ADDR=0 and OP_B_ADDR=1
- Single module, no sub-module. The TX push logic is small enough to live as shared states.

## Test plan
- Write: bytes AA, 05, 3C → one WrEn pulse with Address=5 and WrData=3C. No TX_D_VALID.
- Read: bytes BB, 05; RdData=3C with RdData_Valid 2 cycles later → one RdEn with Address=5, then TX_D_VALID with TX_P_DATA=3C.
- ALU with operands: bytes CC, 0A, 03, 00; ALU_OUT=000D with OUT_Valid → WrEn at addr 0 (0A) and addr 1 (03), CLK_EN high around an ALU_EN with ALU_FUN=0, then TX bytes 0D then 00.
- TX back-pressure: bytes DD, 02 with FIFO_FULL held high for 5 cycles after OUT_Valid (ALU_OUT=1234) → TX_P_DATA holds 34 with no strobe, then 34 and 12 are pushed once each.
- Robustness:
  - Unknown byte 55 in IDLE → no outputs.
  - RST asserted after AA, 05 → no WrEn.
  - After reset release, a fresh AA, 01, FF writes correctly.
